fpu_bus_iface: RTL and testbench

//  8-bit CPU-bus front end for the fpu block: sits between the CPU data bus and fpu.
//  It assembles 32-bit operands byte by byte, issues the op on start and holds start until cmd_end.
//  It then captures ieee_packet_out into readable result bytes and raises a level irq.

---
 rtl/fpu_bus_iface_pkg.sv | 32 +++
 rtl/fpu_bus_iface_regfile.sv | 55 +++++
 rtl/fpu_bus_iface.sv | 148 ++++++++++++++
 tb/tb_fpu_bus_iface.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_bus_iface_pkg.sv
// Shared types and constants for the fpu CPU-bus front end.
// Holds op codes, register map, STATUS bit positions and the interface FSM states.
package pa_fpu;

  typedef enum logic [3:0] {
    op_add = 4'd0,
    op_sub = 4'd1,
    op_mul = 4'd2,
    op_div = 4'd3
  } e_fpu_op;

  typedef enum logic {
    IDLE,
    RUN
  } e_fpu_if_state;

  localparam logic [3:0] FPU_REG_A0     = 4'd0;
  localparam logic [3:0] FPU_REG_B0     = 4'd4;
  localparam logic [3:0] FPU_REG_R0     = 4'd8;
  localparam logic [3:0] FPU_REG_CMD    = 4'd12;
  localparam logic [3:0] FPU_REG_STATUS = 4'd13;

  localparam int unsigned ST_BUSY     = 0;
  localparam int unsigned ST_DONE     = 1;
  localparam int unsigned ST_ERR      = 2;
  localparam int unsigned ST_FPU_BUSY = 3;

  function automatic bit op_code_valid(logic [3:0] code);
    return code <= 4'd3;
  endfunction

endpackage

// File: rtl/fpu_bus_iface_regfile.sv
// Byte-addressed A/B operand and R result storage with the byte read mux.
// R is loaded only as a whole word from the fpu result.
module fpu_bus_regfile
  import pa_fpu::*;
(
  input  logic        clk,
  input  logic        arst,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [7:0]  wdata,
  input  logic        cap,
  input  logic [31:0] cap_data,
  input  logic [3:0]  raddr,
  output logic [7:0]  rdata,
  output logic [31:0] a_word,
  output logic [31:0] b_word
);

  logic [31:0] a_q, b_q, r_q;
  logic [4:0]  wsel, rsel;

  assign wsel = {waddr[1:0], 3'b000};
  assign rsel = {raddr[1:0], 3'b000};

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
    end else begin
      if (we) begin
        case (waddr[3:2])
          2'd0:    a_q[wsel +: 8] <= wdata;
          2'd1:    b_q[wsel +: 8] <= wdata;
          default: ;
        endcase
      end
      if (cap) r_q <= cap_data;
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (raddr[3:2])
      2'd0:    rdata = a_q[rsel +: 8];
      2'd1:    rdata = b_q[rsel +: 8];
      2'd2:    rdata = r_q[rsel +: 8];
      default: rdata = 8'h00;
    endcase
  end

  assign a_word = a_q;
  assign b_word = b_q;

endmodule

// File: rtl/fpu_bus_iface.sv
// 8-bit CPU-bus front end for the fpu: operand assembly, op issue with timeout,
// result capture, STATUS flags and a level completion interrupt.
module fpu_bus_iface
  import pa_fpu::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          IRQ_EN         = 1'b1
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        cs,
  input  logic        wr,
  input  logic        rd,
  input  logic [3:0]  addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        irq,
  output logic [31:0] fpu_a_operand,
  output logic [31:0] fpu_b_operand,
  output e_fpu_op     fpu_operation,
  output logic        fpu_start,
  input  logic [31:0] fpu_result,
  input  logic        fpu_cmd_end,
  input  logic        fpu_busy
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  e_fpu_if_state   state_q, state_d;
  e_fpu_op         op_q, op_d;
  logic            start_q, start_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            irq_q, irq_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cap;
  logic            wr_en, rd_status, is_ab, is_cmd, rf_we;
  logic [7:0]      rf_rdata, status;

  assign wr_en     = cs & wr;
  assign rd_status = cs & rd & (addr == FPU_REG_STATUS);
  assign is_ab     = (addr < FPU_REG_R0);
  assign is_cmd    = (addr == FPU_REG_CMD);
  // Operands are frozen while an op is in flight.
  assign rf_we     = wr_en & is_ab & (state_q == IDLE);

  fpu_bus_regfile u_regfile (
    .clk      (clk),
    .arst     (arst),
    .we       (rf_we),
    .waddr    (addr),
    .wdata    (data_in),
    .cap      (cap),
    .cap_data (fpu_result),
    .raddr    (addr),
    .rdata    (rf_rdata),
    .a_word   (fpu_a_operand),
    .b_word   (fpu_b_operand)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      op_q    <= op_add;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read-clear is applied first so that any set in the same edge wins.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    start_d = start_q;
    done_d  = done_q;
    err_d   = err_q;
    irq_d   = irq_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    if (rd_status) begin
      done_d = 1'b0;
      err_d  = 1'b0;
      irq_d  = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (wr_en && is_cmd) begin
          if (op_code_valid(data_in[3:0])) begin
            op_d    = e_fpu_op'(data_in[3:0]);
            start_d = 1'b1;
            done_d  = 1'b0;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (wr_en && (is_ab || is_cmd)) err_d = 1'b1;
        if (fpu_cmd_end) begin
          cap     = 1'b1;
          start_d = 1'b0;
          done_d  = 1'b1;
          irq_d   = IRQ_EN;
          state_d = IDLE;
        end else if (cnt_q == CntLast) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status              = 8'h00;
    status[ST_BUSY]     = (state_q != IDLE);
    status[ST_DONE]     = done_q;
    status[ST_ERR]      = err_q;
    status[ST_FPU_BUSY] = fpu_busy;
  end

  always_comb begin
    data_out = 8'h00;
    if (cs && rd) data_out = (addr == FPU_REG_STATUS) ? status : rf_rdata;
  end

  assign fpu_start     = start_q;
  assign fpu_operation = op_q;
  assign irq           = IRQ_EN ? irq_q : 1'b0;

endmodule

// File: tb/tb_fpu_bus_iface.sv
// Directed bench for fpu_bus_iface: table-driven register access plus sequences
// for op issue, capture, status clear, invalid op, run-time writes, timeout and reset.
module tb_fpu_bus_iface;
  import pa_fpu::*;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        irq;
  logic [31:0] fpu_a_operand, fpu_b_operand;
  e_fpu_op     fpu_operation;
  logic        fpu_start;
  logic [31:0] fpu_result = 32'h0;
  logic        fpu_cmd_end = 1'b0;
  logic        fpu_busy = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fpu_bus_iface #(
    .TIMEOUT_CYCLES (1024),
    .IRQ_EN         (1'b1)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .cs            (cs),
    .wr            (wr),
    .rd            (rd),
    .addr          (addr),
    .data_in       (data_in),
    .data_out      (data_out),
    .irq           (irq),
    .fpu_a_operand (fpu_a_operand),
    .fpu_b_operand (fpu_b_operand),
    .fpu_operation (fpu_operation),
    .fpu_start     (fpu_start),
    .fpu_result    (fpu_result),
    .fpu_cmd_end   (fpu_cmd_end),
    .fpu_busy      (fpu_busy)
  );

  typedef struct {
    logic       do_wr;
    logic [3:0] a;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; data_in = d;
    @(posedge clk);
    #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    #1 d = data_out;
    @(posedge clk);
    #1;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic end_op(input logic [31:0] res);
    @(negedge clk);
    fpu_result = res; fpu_cmd_end = 1'b1;
    @(posedge clk);
    #1;
    fpu_cmd_end = 1'b0;
  endtask

  logic [7:0] rb;
  int         n;

  initial begin
    vecs[0]  = '{1'b1, 4'd0,  8'h00, 8'h00};
    vecs[1]  = '{1'b1, 4'd1,  8'h00, 8'h00};
    vecs[2]  = '{1'b1, 4'd2,  8'h80, 8'h80};
    vecs[3]  = '{1'b1, 4'd3,  8'h3e, 8'h3e};
    vecs[4]  = '{1'b1, 4'd4,  8'h00, 8'h00};
    vecs[5]  = '{1'b1, 4'd5,  8'h00, 8'h00};
    vecs[6]  = '{1'b1, 4'd6,  8'h00, 8'h00};
    vecs[7]  = '{1'b1, 4'd7,  8'h3f, 8'h3f};
    vecs[8]  = '{1'b1, 4'd8,  8'hff, 8'h00};
    vecs[9]  = '{1'b1, 4'd14, 8'haa, 8'h00};
    vecs[10] = '{1'b0, 4'd15, 8'h00, 8'h00};
    vecs[11] = '{1'b0, 4'd12, 8'h00, 8'h00};
    vecs[12] = '{1'b0, 4'd13, 8'h00, 8'h00};

    // Reset state
    #12;
    check("rst_start", fpu_start, 0);
    check("rst_irq", irq, 0);
    check("rst_a", fpu_a_operand, 0);
    check("rst_op", 32'(fpu_operation), 0);
    @(negedge clk);
    arst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_wr) bus_wr(vecs[i].a, vecs[i].wdata);
      bus_rd(vecs[i].a, rb);
      check($sformatf("reg_vec%0d", i), rb, vecs[i].exp);
    end
    check("a_operand", fpu_a_operand, 32'h3e800000);
    check("b_operand", fpu_b_operand, 32'h3f000000);

    fpu_busy = 1'b1;
    bus_rd(FPU_REG_STATUS, rb);
    check("status_fpu_busy", rb, 8'h08);
    fpu_busy = 1'b0;

    // 1: multiply, start held until cmd_end, result capture
    bus_wr(FPU_REG_CMD, 8'h02);
    check("t1_start", fpu_start, 1);
    check("t1_op", 32'(fpu_operation), 32'(op_mul));
    repeat (3) @(posedge clk);
    #1 check("t1_start_held", fpu_start, 1);
    end_op(32'h3e000000);
    check("t1_start_drop", fpu_start, 0);
    check("t1_irq", irq, 1);
    for (int i = 0; i < 4; i++) begin
      bus_rd(FPU_REG_R0 + 4'(i), rb);
      check($sformatf("t1_r%0d", i), rb, 8'(32'h3e000000 >> (8 * i)));
    end

    // 2: status read clears done/irq
    bus_rd(FPU_REG_STATUS, rb);
    check("t2_status", rb, 8'h02);
    check("t2_irq", irq, 0);
    bus_rd(FPU_REG_STATUS, rb);
    check("t2_status2", rb, 8'h00);

    // 3: invalid op code
    bus_wr(FPU_REG_CMD, 8'h0f);
    check("t3_start", fpu_start, 0);
    bus_rd(FPU_REG_STATUS, rb);
    check("t3_status", rb, 8'h04);

    // 4: operand write during RUN is ignored and flagged
    bus_wr(FPU_REG_CMD, 8'h00);
    bus_wr(FPU_REG_A0, 8'hff);
    check("t4_a_stable", fpu_a_operand, 32'h3e800000);
    end_op(32'h12345678);
    bus_rd(FPU_REG_STATUS, rb);
    check("t4_status", rb, 8'h06);
    bus_rd(FPU_REG_A0, rb);
    check("t4_a0", rb, 8'h00);

    // 5: timeout with no cmd_end
    bus_wr(FPU_REG_CMD, 8'h03);
    check("t5_start", fpu_start, 1);
    n = 0;
    while (fpu_start && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
    check("t5_cycles", n, 1024);
    bus_rd(FPU_REG_STATUS, rb);
    check("t5_status", rb, 8'h04);
    bus_rd(FPU_REG_R0, rb);
    check("t5_r0_kept", rb, 8'h78);

    // Status read in the same edge as capture: pre-capture value, set wins
    bus_wr(FPU_REG_CMD, 8'h02);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = FPU_REG_STATUS;
    fpu_result = 32'hcafef00d; fpu_cmd_end = 1'b1;
    #1 rb = data_out;
    @(posedge clk);
    #1;
    cs = 1'b0; rd = 1'b0; fpu_cmd_end = 1'b0;
    check("same_edge_read", rb, 8'h01);
    check("same_edge_irq", irq, 1);

    // Back-to-back: CMD in the edge after capture; irq left pending
    bus_wr(FPU_REG_CMD, 8'h01);
    check("b2b_start", fpu_start, 1);
    check("b2b_op", 32'(fpu_operation), 32'(op_sub));
    check("b2b_irq_pending", irq, 1);

    // 6: async reset mid-op
    @(negedge clk);
    #1 arst = 1'b1;
    #1;
    check("t6_start_async", fpu_start, 0);
    check("t6_irq", irq, 0);
    check("t6_a", fpu_a_operand, 0);
    check("t6_b", fpu_b_operand, 0);
    @(negedge clk);
    arst = 1'b0;
    bus_rd(FPU_REG_R0 + 4'd3, rb);
    check("t6_r3", rb, 8'h00);
    bus_rd(FPU_REG_STATUS, rb);
    check("t6_status", rb, 8'h00);
    repeat (2) @(posedge clk);
    #1 check("t6_no_restart", fpu_start, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
